ctrl_seq: RTL and testbench

- Parametrised, sequential successor to the single-opcode combinational control decoder.
- Decodes the opcode field of the fetched instruction into datapath and fetch-unit controls.
- Owns the architectural Zero flag, so conditional branches resolve inside the block.
- Adds a run/idle/halt state machine and a multi-cycle load stall. Sits between instruction ROM/ALU and program_counter, register file and data memory.

---
 rtl/ctrl_seq.sv | 126 ++++++++++++
 tb/tb_ctrl_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// Sequential control unit: decodes the opcode field into datapath/fetch controls,
// owns the Zero flag and sequences idle/run/halt plus a multi-cycle load stall.
module ctrl_seq #(
    parameter int             IW       = 9,
    parameter int             OPW      = 4,
    parameter int             OP_LSB   = 5,
    parameter int             LOAD_LAT = 2,
    parameter logic [OPW-1:0] OP_NOP   = 4'b0000,
    parameter logic [OPW-1:0] OP_LOAD  = 4'b0100,
    parameter logic [OPW-1:0] OP_STORE = 4'b0101,
    parameter logic [OPW-1:0] OP_JUMP  = 4'b1100,
    parameter logic [OPW-1:0] OP_BZ    = 4'b1101,
    parameter logic [OPW-1:0] OP_HALT  = 4'b1111
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic          ZeroIn,
    output logic          Jump,
    output logic          BranchEn,
    output logic          PcEn,
    output logic          RegWrite,
    output logic          MemRead,
    output logic          MemWrite,
    output logic          ZeroFlag,
    output logic          Halted
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        LOAD_WAIT = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(LOAD_LAT - 1);

    state_t           state;
    state_t           next_state;
    logic             zero_flag;
    logic             next_zero;
    logic [3:0]       count;
    logic [3:0]       next_count;
    logic [OPW-1:0]   op;
    logic             unused_instr_bits;

    assign op                = Instruction[OP_LSB+OPW-1:OP_LSB];
    assign unused_instr_bits = ^Instruction;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            zero_flag <= 1'b0;
            count     <= 4'd0;
        end else begin
            state     <= next_state;
            zero_flag <= next_zero;
            count     <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_zero  = zero_flag;
        next_count = count;
        Jump       = 1'b0;
        PcEn       = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;

        case (state)
            IDLE: begin
                if (Start) next_state = RUN;
            end

            RUN: begin
                PcEn = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_LOAD: begin
                        MemRead    = 1'b1;
                        PcEn       = 1'b0;
                        next_count = WAIT_INIT;
                        next_state = LOAD_WAIT;
                    end
                    OP_STORE: MemWrite = 1'b1;
                    OP_JUMP:  Jump = 1'b1;
                    // Branch resolves on the flag as it stood before this edge.
                    OP_BZ:    Jump = zero_flag;
                    OP_HALT: begin
                        PcEn       = 1'b0;
                        next_state = HALT;
                    end
                    default: begin
                        RegWrite  = 1'b1;
                        next_zero = ZeroIn;
                    end
                endcase
            end

            LOAD_WAIT: begin
                MemRead = 1'b1;
                if (count == 4'd0) begin
                    RegWrite   = 1'b1;
                    PcEn       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_count = count - 4'd1;
                end
            end

            HALT: begin
                if (Start) next_state = RUN;
            end

            default: next_state = IDLE;
        endcase
    end

    assign BranchEn = Jump;
    assign ZeroFlag = zero_flag;
    assign Halted   = (state == HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: two instances (LOAD_LAT=2 and 1) driven by shared stimulus,
// checked every cycle against an instruction-level reference model.
module tb_ctrl_seq;

    localparam int IW = 9;
    localparam int OPW = 4;
    localparam int OP_LSB = 5;

    localparam logic [3:0] C_NOP   = 4'b0000;
    localparam logic [3:0] C_LOAD  = 4'b0100;
    localparam logic [3:0] C_STORE = 4'b0101;
    localparam logic [3:0] C_JUMP  = 4'b1100;
    localparam logic [3:0] C_BZ    = 4'b1101;
    localparam logic [3:0] C_HALT  = 4'b1111;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOAD = 2;
    localparam int M_HALT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] instr;
    logic          zin;

    logic jump_a, br_a, pc_a, rw_a, mr_a, mw_a, zf_a, h_a;
    logic jump_b, br_b, pc_b, rw_b, mr_b, mw_b, zf_b, h_b;

    always #5 clk = ~clk;

    ctrl_seq #(.IW(IW), .OPW(OPW), .OP_LSB(OP_LSB), .LOAD_LAT(2)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Instruction(instr), .ZeroIn(zin),
        .Jump(jump_a), .BranchEn(br_a), .PcEn(pc_a), .RegWrite(rw_a),
        .MemRead(mr_a), .MemWrite(mw_a), .ZeroFlag(zf_a), .Halted(h_a)
    );

    ctrl_seq #(.IW(IW), .OPW(OPW), .OP_LSB(OP_LSB), .LOAD_LAT(1)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Start(start), .Instruction(instr), .ZeroIn(zin),
        .Jump(jump_b), .BranchEn(br_b), .PcEn(pc_b), .RegWrite(rw_b),
        .MemRead(mr_b), .MemWrite(mw_b), .ZeroFlag(zf_b), .Halted(h_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model per instance: mode, load cycles still to go, Zero flag.
    int mode[2];
    int left[2];
    bit zf[2];
    int lat[2] = '{2, 1};

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h (J BE PC RW MR MW ZF H)", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cur_op();
        logic [IW-1:0] w;
        w = instr;
        return w[OP_LSB +: OPW];
    endfunction

    function automatic logic [7:0] model_out(input int k);
        logic j, pe, rw, mr, mw, h;
        logic [3:0] o;
        j = 0; pe = 0; rw = 0; mr = 0; mw = 0; h = 0;
        o = cur_op();
        if (mode[k] == M_RUN) begin
            pe = 1;
            if (o == C_LOAD) begin mr = 1; pe = 0; end
            else if (o == C_STORE) mw = 1;
            else if (o == C_JUMP) j = 1;
            else if (o == C_BZ) j = zf[k];
            else if (o == C_HALT) pe = 0;
            else if (o != C_NOP) rw = 1;
        end else if (mode[k] == M_LOAD) begin
            mr = 1;
            if (left[k] == 1) begin rw = 1; pe = 1; end
        end else if (mode[k] == M_HALT) begin
            h = 1;
        end
        return {j, j, pe, rw, mr, mw, zf[k], h};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = M_IDLE;
            left[k] = 0;
            zf[k]   = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] o;
        o = cur_op();
        for (int k = 0; k < 2; k++) begin
            case (mode[k])
                M_IDLE, M_HALT: if (start) mode[k] = M_RUN;
                M_RUN: begin
                    if (o == C_LOAD) begin mode[k] = M_LOAD; left[k] = lat[k]; end
                    else if (o == C_HALT) mode[k] = M_HALT;
                    else if (o != C_NOP && o != C_STORE && o != C_JUMP && o != C_BZ)
                        zf[k] = zin;
                end
                default: begin
                    if (left[k] == 1) mode[k] = M_RUN;
                    else left[k] = left[k] - 1;
                end
            endcase
        end
    endtask

    task automatic compare(input string tag);
        check_eq({tag, "_lat2"}, {jump_a, br_a, pc_a, rw_a, mr_a, mw_a, zf_a, h_a}, model_out(0));
        check_eq({tag, "_lat1"}, {jump_b, br_b, pc_b, rw_b, mr_b, mw_b, zf_b, h_b}, model_out(1));
    endtask

    task automatic cycle(input bit s, input logic [3:0] o, input bit z, input string tag);
        logic [IW-1:0] w;
        @(negedge clk);
        w = IW'($urandom);
        w[OP_LSB +: OPW] = o;
        start = s;
        instr = w;
        zin   = z;
        #1;
        compare(tag);
        @(posedge clk);
        model_step();
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] alu_ops [10] = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE};
        int r;
        r = $urandom_range(0, 19);
        if (r < 8) return alu_ops[$urandom_range(0, 9)];
        case (r)
            8, 9:   return C_NOP;
            10, 11: return C_LOAD;
            12, 13: return C_STORE;
            14, 15: return C_JUMP;
            16, 17: return C_BZ;
            default: return C_HALT;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        instr = '0;
        zin   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_a", {jump_a, br_a, pc_a, rw_a, mr_a, mw_a, zf_a, h_a}, 8'h00);
        check_eq("reset_b", {jump_b, br_b, pc_b, rw_b, mr_b, mw_b, zf_b, h_b}, 8'h00);
        rst_n = 1'b1;

        cycle(0, 4'b0001, 1, "idle_hold");
        cycle(1, 4'b0001, 1, "idle_start");
        cycle(0, 4'b0001, 1, "run_alu_z1");
        cycle(0, C_BZ, 0, "bz_taken");
        cycle(0, 4'b0010, 0, "alu_z0");
        cycle(0, C_BZ, 1, "bz_not_taken");
        cycle(0, C_LOAD, 0, "load_issue");
        cycle(0, C_NOP, 0, "load_c1");
        cycle(0, C_NOP, 0, "load_c2");
        cycle(0, C_NOP, 0, "after_load");
        cycle(0, C_STORE, 1, "store_z_kept");
        cycle(0, C_JUMP, 1, "jump");
        cycle(0, 4'b0011, 1, "alu_z1_again");
        cycle(0, C_HALT, 0, "halt_issue");
        for (int i = 0; i < 10; i++) cycle(0, C_NOP, 0, "halt_hold");
        cycle(1, C_NOP, 0, "halt_start");
        cycle(0, C_BZ, 0, "resume_bz");

        // Asynchronous reset in the first load-wait cycle.
        cycle(0, C_LOAD, 0, "load_before_rst");
        @(negedge clk);
        start = 1'b0;
        instr = '0;
        zin   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_a", {jump_a, br_a, pc_a, rw_a, mr_a, mw_a, zf_a, h_a}, 8'h00);
        check_eq("async_rst_b", {jump_b, br_b, pc_b, rw_b, mr_b, mw_b, zf_b, h_b}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 4'b0001, 1, "post_rst_idle");
        cycle(0, C_STORE, 1, "post_rst_idle2");
        cycle(1, C_NOP, 0, "post_rst_start");

        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 7) == 0), rand_op(), 1'($urandom), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
